vga_rx_timing: RTL
==================

// Module: vga_rx_timing
// PURPOSE
//  Receive-side counterpart of the VGA/DVI timing generator. Samples incoming HS/VS/DE/RGB on pix_clk.
//  Recovers per-pixel x/y coordinates, start-of-frame and end-of-line marks, and measures active width/height.
//  Runs a lock FSM against the expected format. Sits at the video input, feeding the defog pipeline.
// PARAMETERS
//  H_ACT_EXP  1280     expected active pixels per line
//  V_ACT_EXP  720      expected active lines per frame
//  LOCK_FRM   2        consecutive matching frames required to lock (>=1)
//  TIMEOUT    2000000  pix_clk cycles without a DE rising edge before lock is dropped (24-bit counter)
// PORTS
//  pix_clk      in   1   pixel clock
//  reset_n      in   1   asynchronous active-low reset
//  vin_hs       in   1   hsync; active low, idle high
//  vin_vs       in   1   vsync; active low, idle high
//  vin_de       in   1   data enable
//  vin_rgb      in   24  {R[23:16],G[15:8],B[7:0]}
//  pix_valid    out  1   pix_data/x/y valid
//  pix_data     out  24  delayed vin_rgb
//  pix_x        out  12  column 0..width-1
//  pix_y        out  12  row 0..height-1
//  pix_sof      out  1   first active pixel of frame (x=0,y=0)
//  pix_eol      out  1   last active pixel of a line
//  meas_width   out  12  DE-high length of the most recent line
//  meas_height  out  12  DE lines counted in the last complete frame
//  locked       out  1   format locked
//  fmt_err      out  1   1-cycle pulse: frame failed the format check
// BEHAVIOUR
//  Reset: all outputs 0; FSM=SEARCH; s1/s2 hs,vs=1, de=0.
//  Pipeline: s1<=inputs, s2<=s1, outputs registered from (s2,s1). Latency is exactly 3 cycles input->output.
//  Edges come from s2 vs s1:
//   vs_fall = s2.vs & ~s1.vs.
//   de_rise = ~s2.de & s1.de.
//   de_fall = s2.de & ~s1.de.
//   pix_eol = s2.de & ~s1.de, qualified as pix_valid.
//  x_cnt: cleared on de_rise, +1 per DE-high cycle, saturates at 4095.
//  On de_fall: meas_width<=x_cnt; line_cnt+1 (saturate 4095); width_bad|=(x_cnt!=H_ACT_EXP).
//  On vs_fall:
//   - meas_height<=line_cnt; check frame: good = (line_cnt==V_ACT_EXP)&~width_bad.
//   - Then clear line_cnt, width_bad; arm sof.
//  Same-cycle de_fall+vs_fall: line end is applied first (that line counts in the closing frame).
//  pix_x=x_cnt, pix_y=line_cnt for the active pixel. pix_sof: first valid pixel after arm, then disarm.
//  pix_valid = s2.de & (FSM!=SEARCH). pix_data/x/y/sof/eol are forced 0 when not valid.
//  FSM:
//   SEARCH: first vs_fall -> VERIFY, good_cnt=0. Partial frame is not checked, no fmt_err.
//   VERIFY: vs_fall & good -> good_cnt+1; reaching LOCK_FRM -> LOCKED, locked=1.
//           vs_fall & ~good -> good_cnt=0, fmt_err pulse, stay VERIFY.
//   LOCKED: vs_fall & ~good -> VERIFY, good_cnt=0, locked=0, fmt_err pulse.
//   Any state: TIMEOUT cycles without de_rise -> SEARCH, locked=0, no fmt_err.
//              Timeout counter saturates; it clears on de_rise and on reset.
//  Reset mid-frame: async clear to reset values. The next vs_fall restarts as from SEARCH.
// TESTING
//  1. 1280x720 stream, H_Total=1650, V_Total=750 -> meas_width=1280, meas_height=720.
//     locked=1 on the cycle after the output-side vs_fall ending the 2nd complete frame.
//  2. Same stream -> one pix_sof per frame at x=0,y=0; 720 pix_eol per frame, each at x=1279.
//     pix_valid lags vin_de by exactly 3 cycles.
//  3. Locked; one line of 1279 pixels -> fmt_err 1-cycle pulse at next vs_fall, locked=0.
//     Re-lock after 2 good frames.
//  4. Locked; vin_de held 0 for TIMEOUT+1 cycles -> locked=0, fmt_err=0, pix_valid=0 until next vs_fall.
//  5. reset_n low at y=300 -> all outputs 0 immediately (async).
//     After release: no pix_valid or sof before next vs_fall; lock needs 2 full frames.
//  6. H_ACT_EXP=8, V_ACT_EXP=4, LOCK_FRM=1; DE falls on the same cycle as VS falls -> meas_height=4, lock in 1 frame.

Source files
------------

// File: rtl/vga_rx_timing.sv
// rtl/vga_rx_timing.sv - video input timing recovery, format measurement and lock tracking
module vga_rx_timing #(
    parameter int H_ACT_EXP = 1280,
    parameter int V_ACT_EXP = 720,
    parameter int LOCK_FRM  = 2,
    parameter int TIMEOUT   = 2000000
) (
    input  logic        pix_clk,
    input  logic        reset_n,
    input  logic        vin_hs,
    input  logic        vin_vs,
    input  logic        vin_de,
    input  logic [23:0] vin_rgb,
    output logic        pix_valid,
    output logic [23:0] pix_data,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic [11:0] meas_width,
    output logic [11:0] meas_height,
    output logic        locked,
    output logic        fmt_err
);

    localparam int              GW     = $clog2(LOCK_FRM + 1);
    localparam logic [11:0]     H_EXP  = 12'(H_ACT_EXP);
    localparam logic [11:0]     V_EXP  = 12'(V_ACT_EXP);
    localparam logic [23:0]     TO_LIM = 24'(TIMEOUT);
    localparam logic [GW-1:0]   LOCK_N = GW'(LOCK_FRM);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [GW-1:0]  good_cnt;
    logic [GW-1:0]  good_nxt;
    logic           fmt_err_nxt;

    logic           s1_hs, s1_vs, s1_de;
    logic [23:0]    s1_rgb;
    logic           s2_hs, s2_vs, s2_de;
    logic [23:0]    s2_rgb;

    logic [11:0]    x_cnt;
    logic [11:0]    line_cnt;
    logic           width_bad;
    logic [23:0]    to_cnt;
    logic           sof_arm;

    logic           vs_fall, de_rise, de_fall;
    logic [11:0]    x_inc;
    logic [11:0]    line_cnt_eol;
    logic           width_bad_eol;
    logic           frame_good;
    logic           timeout;
    logic           valid_d;
    logic [GW-1:0]  good_inc;

    // hsync is carried through the sampling stages with the rest of the bus, but line timing comes from DE
    logic           unused_hs;
    assign unused_hs = s2_hs;

    // two input sampling stages; edges are detected between them
    always_ff @(posedge pix_clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_hs  <= 1'b1;
            s1_vs  <= 1'b1;
            s1_de  <= 1'b0;
            s1_rgb <= '0;
            s2_hs  <= 1'b1;
            s2_vs  <= 1'b1;
            s2_de  <= 1'b0;
            s2_rgb <= '0;
        end else begin
            s1_hs  <= vin_hs;
            s1_vs  <= vin_vs;
            s1_de  <= vin_de;
            s1_rgb <= vin_rgb;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s2_de  <= s1_de;
            s2_rgb <= s1_rgb;
        end
    end

    // edge detection and the line-end view of the counters (line end is folded in before any frame end)
    always_comb begin
        vs_fall       = s2_vs & ~s1_vs;
        de_rise       = ~s2_de & s1_de;
        de_fall       = s2_de & ~s1_de;
        x_inc         = (x_cnt == 12'hFFF) ? x_cnt : x_cnt + 12'd1;
        line_cnt_eol  = line_cnt;
        width_bad_eol = width_bad;
        if (de_fall) begin
            line_cnt_eol  = (line_cnt == 12'hFFF) ? line_cnt : line_cnt + 12'd1;
            width_bad_eol = width_bad | (x_inc != H_EXP);
        end
        frame_good = (line_cnt_eol == V_EXP) & ~width_bad_eol;
        timeout    = (to_cnt >= TO_LIM);
        valid_d    = s2_de & (state != ST_SEARCH);
        good_inc   = good_cnt + 1'b1;
    end

    // pixel/line counters, measurements, DE watchdog and start-of-frame arming
    always_ff @(posedge pix_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt       <= '0;
            line_cnt    <= '0;
            width_bad   <= 1'b0;
            meas_width  <= '0;
            meas_height <= '0;
            to_cnt      <= '0;
            sof_arm     <= 1'b0;
        end else begin
            if (de_rise) begin
                x_cnt <= '0;
            end else if (s2_de) begin
                x_cnt <= x_inc;
            end
            // x_cnt holds the index of the last pixel, so the line length is one more
            if (de_fall) begin
                meas_width <= x_inc;
            end
            if (vs_fall) begin
                meas_height <= line_cnt_eol;
                line_cnt    <= '0;
                width_bad   <= 1'b0;
            end else begin
                line_cnt    <= line_cnt_eol;
                width_bad   <= width_bad_eol;
            end
            if (de_rise) begin
                to_cnt <= '0;
            end else if (to_cnt != '1) begin
                to_cnt <= to_cnt + 24'd1;
            end
            // a pixel landing on the frame-end cycle belongs to the old frame, so arming wins
            if (vs_fall) begin
                sof_arm <= 1'b1;
            end else if (valid_d) begin
                sof_arm <= 1'b0;
            end
        end
    end

    // registered pixel outputs, zeroed whenever the pixel is not valid
    always_ff @(posedge pix_clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
        end else begin
            pix_valid <= valid_d;
            pix_data  <= valid_d ? s2_rgb : 24'd0;
            pix_x     <= valid_d ? x_cnt : 12'd0;
            pix_y     <= valid_d ? line_cnt : 12'd0;
            pix_sof   <= valid_d & sof_arm;
            pix_eol   <= valid_d & de_fall;
        end
    end

    // lock FSM state register, good-frame counter and the format error pulse
    always_ff @(posedge pix_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_SEARCH;
            good_cnt <= '0;
            fmt_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            fmt_err  <= fmt_err_nxt;
        end
    end

    // lock FSM next state; loss of DE overrides any frame-end decision and is not a format error
    always_comb begin
        state_nxt   = state;
        good_nxt    = good_cnt;
        fmt_err_nxt = 1'b0;
        if (timeout) begin
            state_nxt = ST_SEARCH;
            good_nxt  = '0;
        end else if (vs_fall) begin
            case (state)
                ST_SEARCH: begin
                    state_nxt = ST_VERIFY;
                    good_nxt  = '0;
                end
                ST_VERIFY: begin
                    if (frame_good) begin
                        if (good_inc == LOCK_N) begin
                            state_nxt = ST_LOCKED;
                            good_nxt  = '0;
                        end else begin
                            good_nxt  = good_inc;
                        end
                    end else begin
                        good_nxt    = '0;
                        fmt_err_nxt = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!frame_good) begin
                        state_nxt   = ST_VERIFY;
                        good_nxt    = '0;
                        fmt_err_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_SEARCH;
                    good_nxt  = '0;
                end
            endcase
        end
    end

    // lock FSM outputs
    always_comb begin
        locked = (state == ST_LOCKED);
    end

endmodule
